// File: rtl/ball_video_tracker.sv
// Rebuilds pixel coordinates from the hvsync bus and reports the bounding box of target-coloured pixels per frame.
// Optional macro BALL_VIDEO_TRACKER_VEL_EN adds frame-to-frame xmin/ymin deltas on obj_dx/obj_dy/vel_valid.
module ball_video_tracker #(
  parameter int H_DISPLAY = 256,
  parameter int V_DISPLAY = 240,
  parameter int H_BACK = 23,
  parameter int V_BACK = 5,
  parameter logic [2:0] TARGET_RGB = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb,
  output logic [8:0] obj_xmin,
  output logic [8:0] obj_xmax,
  output logic [8:0] obj_ymin,
  output logic [8:0] obj_ymax,
  output logic       obj_found,
  output logic       frame_strobe,
  output logic [9:0] obj_dx,
  output logic [9:0] obj_dy,
  output logic       vel_valid
);

  typedef enum logic [1:0] {SYNC_WAIT, SCAN, REPORT} state_t;

  localparam logic [9:0] X_LO = 10'(H_BACK);
  localparam logic [9:0] X_HI = 10'(H_BACK + H_DISPLAY);
  localparam logic [9:0] Y_LO = 10'(V_BACK);
  localparam logic [9:0] Y_HI = 10'(V_BACK + V_DISPLAY);
  localparam logic [8:0] X_OFF = 9'(H_BACK);
  localparam logic [8:0] Y_OFF = 9'(V_BACK);

  state_t     state;
  logic       hs_r, vs_r, hs_d, vs_d;
  logic [2:0] rgb_r;
  logic [8:0] x_cnt, y_cnt;
  logic [8:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic       acc_any;
  logic       hs_fall, vs_fall, vs_rise;
  logic       x_valid, y_valid, hit, report_now;
  logic [8:0] px, py;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      hs_d  <= 1'b0;
      vs_d  <= 1'b0;
      rgb_r <= 3'b000;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      rgb_r <= rgb;
      hs_d  <= hs_r;
      vs_d  <= vs_r;
    end
  end

  assign hs_fall = hs_d & ~hs_r;
  assign vs_fall = vs_d & ~vs_r;
  assign vs_rise = ~vs_d & vs_r;

  // Counters saturate so a stalled sync can never wrap back into the visible window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      if (hs_fall)
        x_cnt <= '0;
      else if (x_cnt != 9'd511)
        x_cnt <= x_cnt + 9'd1;
      if (vs_fall)
        y_cnt <= '0;
      else if (hs_fall && y_cnt != 9'd511)
        y_cnt <= y_cnt + 9'd1;
    end
  end

  assign x_valid    = ({1'b0, x_cnt} >= X_LO) && ({1'b0, x_cnt} < X_HI);
  assign y_valid    = ({1'b0, y_cnt} >= Y_LO) && ({1'b0, y_cnt} < Y_HI);
  assign px         = x_cnt - X_OFF;
  assign py         = y_cnt - Y_OFF;
  assign hit        = x_valid && y_valid && !vs_r && (rgb_r == TARGET_RGB);
  assign report_now = (state == SCAN) && vs_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SYNC_WAIT;
      acc_xmin     <= 9'd511;
      acc_xmax     <= '0;
      acc_ymin     <= 9'd511;
      acc_ymax     <= '0;
      acc_any      <= 1'b0;
      obj_xmin     <= '0;
      obj_xmax     <= '0;
      obj_ymin     <= '0;
      obj_ymax     <= '0;
      obj_found    <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      case (state)
        SYNC_WAIT: begin
          frame_strobe <= 1'b0;
          if (vs_fall)
            state <= SCAN;
        end
        SCAN: begin
          if (vs_rise) begin
            obj_xmin     <= acc_any ? acc_xmin : 9'd0;
            obj_xmax     <= acc_any ? acc_xmax : 9'd0;
            obj_ymin     <= acc_any ? acc_ymin : 9'd0;
            obj_ymax     <= acc_any ? acc_ymax : 9'd0;
            obj_found    <= acc_any;
            frame_strobe <= 1'b1;
            acc_xmin     <= 9'd511;
            acc_xmax     <= '0;
            acc_ymin     <= 9'd511;
            acc_ymax     <= '0;
            acc_any      <= 1'b0;
            state        <= REPORT;
          end else if (hit) begin
            if (px < acc_xmin) acc_xmin <= px;
            if (px > acc_xmax) acc_xmax <= px;
            if (py < acc_ymin) acc_ymin <= py;
            if (py > acc_ymax) acc_ymax <= py;
            acc_any <= 1'b1;
          end
        end
        REPORT: begin
          frame_strobe <= 1'b0;
          state        <= SCAN;
        end
        default: state <= SYNC_WAIT;
      endcase
    end
  end

`ifdef BALL_VIDEO_TRACKER_VEL_EN
  logic [8:0] prev_xmin, prev_ymin;
  logic       prev_found;

  // Deltas are only meaningful when the ball was seen in both frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_xmin  <= '0;
      prev_ymin  <= '0;
      prev_found <= 1'b0;
      obj_dx     <= '0;
      obj_dy     <= '0;
      vel_valid  <= 1'b0;
    end else if (report_now) begin
      if (acc_any && prev_found) begin
        obj_dx    <= {1'b0, acc_xmin} - {1'b0, prev_xmin};
        obj_dy    <= {1'b0, acc_ymin} - {1'b0, prev_ymin};
        vel_valid <= 1'b1;
      end else begin
        obj_dx    <= '0;
        obj_dy    <= '0;
        vel_valid <= 1'b0;
      end
      prev_xmin  <= acc_any ? acc_xmin : 9'd0;
      prev_ymin  <= acc_any ? acc_ymin : 9'd0;
      prev_found <= acc_any;
    end
  end
`else
  assign obj_dx    = '0;
  assign obj_dy    = '0;
  assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ball_video_tracker.sv
// Directed-frame bench for ball_video_tracker: synthetic short-line frames with hand-computed boxes.
module tb_ball_video_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync, vsync;
  logic [2:0] rgb;
  logic [8:0] obj_xmin, obj_xmax, obj_ymin, obj_ymax;
  logic       obj_found, frame_strobe, vel_valid;
  logic [9:0] obj_dx, obj_dy;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int strobe_base;

  ball_video_tracker dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .obj_xmin(obj_xmin), .obj_xmax(obj_xmax), .obj_ymin(obj_ymin), .obj_ymax(obj_ymax),
    .obj_found(obj_found), .frame_strobe(frame_strobe),
    .obj_dx(obj_dx), .obj_dy(obj_dy), .vel_valid(vel_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (frame_strobe) strobe_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  // Drive one pixel-clock worth of bus values, then advance to the next negedge.
  task automatic applyStimulus(input logic hs, input logic vs, input logic [2:0] color);
    hsync = hs;
    vsync = vs;
    rgb   = color;
    @(negedge clk);
  endtask

  function automatic bit pix_white(input int mode, input int x, input int y);
    case (mode)
      1: return (x >= 100 && x <= 107 && y >= 50 && y <= 57);
      2: return ((x == 255 || x == 256) && y == 239) || (x == 100 && y == 240);
      3: return (x >= 97 && x <= 99 && y >= 54 && y <= 55);
      4: return (y == 10 && x >= 276);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int line_len(input int mode, input int y);
    if (mode == 4 && y == 10) return 600;
    if (mode == 2 && y == 239) return 290;
    if (mode == 2 && y == 240) return 140;
    if (mode == 1 && y >= 50 && y <= 57) return 140;
    if (mode == 3 && y >= 54 && y <= 55) return 140;
    return 3;
  endfunction

  // Pixel x appears on the bus 24 cycles after the hsync falling edge (two-stage sync + H_BACK).
  task automatic send_line(input int mode, input int y);
    applyStimulus(1'b1, 1'b0, 3'b001);
    for (int c = 0; c < line_len(mode, y); c++)
      applyStimulus(1'b0, 1'b0, pix_white(mode, c - 24, y) ? 3'b111 : 3'b001);
  endtask

  task automatic send_frame_body(input int mode, input int nlines);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 3'b001);
    for (int l = 0; l < nlines; l++) send_line(mode, l - 4);
  endtask

  task automatic send_frame(input int mode);
    strobe_base = strobe_cnt;
    send_frame_body(mode, 246);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 3'b001);
  endtask

  task automatic check_frame(input string tag, input logic found, input logic [8:0] xmin, input logic [8:0] xmax,
                             input logic [8:0] ymin, input logic [8:0] ymax,
                             input logic [9:0] dx, input logic [9:0] dy, input logic vv);
`ifndef BALL_VIDEO_TRACKER_VEL_EN
    dx = '0;
    dy = '0;
    vv = 1'b0;
`endif
    checkOutput({tag, ".strobes"}, strobe_cnt - strobe_base, 1);
    checkOutput({tag, ".strobe_low"}, frame_strobe, 0);
    checkOutput({tag, ".found"}, obj_found, found);
    checkOutput({tag, ".xmin"}, obj_xmin, xmin);
    checkOutput({tag, ".xmax"}, obj_xmax, xmax);
    checkOutput({tag, ".ymin"}, obj_ymin, ymin);
    checkOutput({tag, ".ymax"}, obj_ymax, ymax);
    checkOutput({tag, ".dx"}, obj_dx, dx);
    checkOutput({tag, ".dy"}, obj_dy, dy);
    checkOutput({tag, ".vel_valid"}, vel_valid, vv);
  endtask

  initial begin
    reset = 1'b1;
    hsync = 1'b0;
    vsync = 1'b0;
    rgb   = 3'b000;
    repeat (3) @(negedge clk);
    checkOutput("reset.found", obj_found, 0);
    checkOutput("reset.xmin", obj_xmin, 0);
    checkOutput("reset.ymin", obj_ymin, 0);
    checkOutput("reset.strobe", frame_strobe, 0);
    reset = 1'b0;

    // A white line and a vsync rise before any vsync fall must not report.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 3'b001);
    send_line(1, 52);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 3'b001);
    checkOutput("prelude.no_strobe", strobe_cnt, 0);

    send_frame(1);
    check_frame("box1", 1'b1, 9'd100, 9'd107, 9'd50, 9'd57, 10'd0, 10'd0, 1'b0);

    // Asynchronous reset in the middle of a scanned frame.
    strobe_base = strobe_cnt;
    send_frame_body(1, 70);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset.xmin", obj_xmin, 0);
    checkOutput("midreset.xmax", obj_xmax, 0);
    checkOutput("midreset.found", obj_found, 0);
    checkOutput("midreset.no_strobe", strobe_cnt - strobe_base, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    send_frame(1);
    check_frame("box1_after_reset", 1'b1, 9'd100, 9'd107, 9'd50, 9'd57, 10'd0, 10'd0, 1'b0);
    send_frame(0);
    check_frame("grid_only", 1'b0, 9'd0, 9'd0, 9'd0, 9'd0, 10'd0, 10'd0, 1'b0);
    send_frame(2);
    check_frame("corner", 1'b1, 9'd255, 9'd255, 9'd239, 9'd239, 10'd0, 10'd0, 1'b0);
    send_frame(4);
    check_frame("hsync_stall", 1'b0, 9'd0, 9'd0, 9'd0, 9'd0, 10'd0, 10'd0, 1'b0);

    send_frame(1);
    check_frame("vel_f1", 1'b1, 9'd100, 9'd107, 9'd50, 9'd57, 10'd0, 10'd0, 1'b0);
    send_frame(3);
    check_frame("vel_f2", 1'b1, 9'd97, 9'd99, 9'd54, 9'd55, 10'h3FD, 10'd4, 1'b1);
    send_frame(1);
    check_frame("vel_f3", 1'b1, 9'd100, 9'd107, 9'd50, 9'd57, 10'd3, 10'h3FC, 1'b1);
    send_frame(0);
    check_frame("vel_empty", 1'b0, 9'd0, 9'd0, 9'd0, 9'd0, 10'd0, 10'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ball_video_tracker.md
Name: ball_video_tracker

Overview:
- Sits on the consumer end of the hvsync_generator video bus.
- Takes hsync, vsync and rgb, rebuilds pixel coordinates from the sync edges, and finds the bounding box of pixels matching a target colour (the ball).
- Reports the box once per frame. Used as a self-check / light-gun style locator fed by ball demo tops.

Parameters:
- H_DISPLAY, 256: visible pixels per line.
- V_DISPLAY, 240: visible lines per frame.
- H_BACK, 23: clock cycles from hsync falling edge (registered) to visible pixel x=0.
- V_BACK, 5: hsync falling edges from vsync falling edge to visible line y=0.
- TARGET_RGB, 3'b111: colour counted as object (rgb bit order {b,g,r}).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hsync  in  1  active-high horizontal sync
- vsync  in  1  active-high vertical sync
- rgb  in  3  pixel colour {b,g,r}
- obj_xmin  out  9  leftmost matching x, last frame
- obj_xmax  out  9  rightmost matching x
- obj_ymin  out  9  topmost matching y
- obj_ymax  out  9  bottommost matching y
- obj_found  out  1  at least one matching pixel in last frame
- frame_strobe  out  1  one-cycle pulse when outputs update
- obj_dx  out  10  signed xmin delta vs previous frame
- obj_dy  out  10  signed ymin delta vs previous frame
- vel_valid  out  1  obj_dx/obj_dy meaningful

Behaviour:
- Input stage: hsync, vsync, rgb registered once; a second hsync/vsync register gives edge detect. All logic uses the registered copies, so input-to-accumulator latency is 1 cycle.
- x_cnt (9b):
  - Cleared on a registered hsync falling edge, else +1.
  - Saturates at 511; never wraps.
  - Pixel x = x_cnt - H_BACK, valid when H_BACK <= x_cnt < H_BACK+H_DISPLAY.
- y_cnt (9b):
  - Cleared on a vsync falling edge, +1 on each hsync falling edge.
  - Saturates at 511.
  - Line y = y_cnt - V_BACK, valid when V_BACK <= y_cnt < V_BACK+V_DISPLAY.
- A pixel counts when x and y are valid, registered vsync=0, and registered rgb == TARGET_RGB. Any other colour is ignored (e.g. grid red 3'b001).
- Accumulators:
  - acc_xmin/acc_ymin init 511; acc_xmax/acc_ymax init 0; acc_any init 0.
  - On each counted pixel: min/max update, acc_any=1.
- FSM states SYNC_WAIT, SCAN, REPORT:
  - SYNC_WAIT: accumulators held at init; on vsync falling edge -> SCAN. Guarantees the first report covers a whole frame.
  - SCAN: accumulate; on vsync rising edge -> REPORT.
  - REPORT (exactly 1 cycle):
    - If acc_any: copy accumulators to obj_* and set obj_found=1; else bbox outputs=0 and obj_found=0.
    - frame_strobe=1.
    - Reinit accumulators, then -> SCAN.
    - No pixel is counted in REPORT (vsync high anyway).
- frame_strobe is high only in the REPORT cycle.
- Outputs hold between strobes.
- Reset, asserted any time including mid-frame:
  - All outputs 0; counters 0; accumulators at init; state SYNC_WAIT; previous-frame registers cleared; prev_found=0.
- Simultaneous hsync and vsync falling edges: y_cnt clear takes priority over increment.

Optional Feature:
- Macro: BALL_VIDEO_TRACKER_VEL_EN.
- Defined:
  - At REPORT, obj_dx = new xmin - prev xmin and obj_dy = new ymin - prev ymin, as 10-bit two's complement.
  - vel_valid=1 only when found in both this and previous frame; otherwise dx=dy=0, vel_valid=0.
  - prev registers then load the new values.
- Undefined: obj_dx, obj_dy, vel_valid tied to 0; no prev registers synthesized.

Test Plan:
- Reset asserted mid-SCAN, then released -> all outputs 0 immediately (async). No frame_strobe until one vsync fall then rise; exactly one strobe per frame after that.
- Synthetic frame with rgb=3'b111 at x=100..107, y=50..57, rest 3'b001 -> strobe once; xmin=100, xmax=107, ymin=50, ymax=57, obj_found=1.
- Frame of only 3'b001 grid pixels -> obj_found=0, all bbox outputs 0, strobe still pulses.
- Single white pixel at x=255,y=239, plus white at x=256 and y=240 (outside display) -> xmin=xmax=255, ymin=ymax=239.
- With BALL_VIDEO_TRACKER_VEL_EN: frame1 box min (100,50), frame2 min (97,54) -> obj_dx=-3 (10'h3FD), obj_dy=+4, vel_valid=1. Frame3 empty -> dx=dy=0, vel_valid=0. Without the macro, all three stay 0.
- Hold hsync low for 600 cycles mid-line with rgb=3'b111 -> x_cnt sticks at 511, no pixel counted past x=255, no wrap-around detections.
